// File: rtl/semaforo_multi.sv
// Round-robin traffic-light controller for N_VIAS approaches plus a pedestrian phase.
// All outputs come straight from flops loaded with the next-state decode.
module semaforo_multi #(
  parameter int unsigned N_VIAS      = 2,
  parameter int unsigned T_VERDE     = 8,
  parameter int unsigned T_AMARELO   = 3,
  parameter int unsigned T_VERMELHO  = 2,
  parameter int unsigned T_VERDE_MIN = 2,
  parameter int unsigned T_PED       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bt,
  output logic [3*N_VIAS-1:0]   luzes,
  output logic                  ped_verde,
  output logic                  pedido,
  output logic [2:0]            via_ativa
);

  typedef enum logic [1:0] {VERDE, AMARELO, VERMELHO, PED} estado_t;

  localparam logic [7:0] T_V1    = 8'(T_VERDE - 1);
  localparam logic [7:0] T_A1    = 8'(T_AMARELO - 1);
  localparam logic [7:0] T_R1    = 8'(T_VERMELHO - 1);
  localparam logic [7:0] T_VMIN1 = 8'(T_VERDE_MIN - 1);
  localparam logic [7:0] T_P1    = 8'(T_PED - 1);
  localparam logic [2:0] VIA_MAX = 3'(N_VIAS - 1);
  localparam logic [3*N_VIAS-1:0] LUZES_RST = {{(N_VIAS-1){3'b100}}, 3'b001};

  estado_t             estado_q, estado_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [2:0]          via_q, via_d, via_prox;
  logic                pedido_q, pedido_d;
  logic                ped_verde_q, ped_verde_d;
  logic [3*N_VIAS-1:0] luzes_q, luzes_d;
  logic                verde_d, amarelo_d;

  assign via_prox = (via_q == VIA_MAX) ? 3'd0 : via_q + 3'd1;

  always_comb begin
    estado_d = estado_q;
    via_d    = via_q;
    pedido_d = pedido_q;
    cnt_d    = cnt_q + 8'd1;
    case (estado_q)
      VERDE:    if (cnt_q == T_V1 || (pedido_q && cnt_q >= T_VMIN1)) estado_d = AMARELO;
      AMARELO:  if (cnt_q == T_A1) estado_d = VERMELHO;
      VERMELHO: if (cnt_q == T_R1) begin
                  if (pedido_q) estado_d = PED;
                  else begin
                    estado_d = VERDE;
                    via_d    = via_prox;
                  end
                end
      PED:      if (cnt_q == T_P1) begin
                  estado_d = VERDE;
                  via_d    = via_prox;
                end
      default:  estado_d = VERDE;
    endcase
    // every transition changes state, so a state change marks an entry
    if (estado_d != estado_q) cnt_d = 8'd0;
    if (bt && estado_q != PED) pedido_d = 1'b1;
    // entering the walk phase serves the request, even one raised at that very edge
    if (estado_d == PED && estado_q != PED) pedido_d = 1'b0;
    ped_verde_d = (estado_d == PED);
    verde_d     = (estado_d == VERDE);
    amarelo_d   = (estado_d == AMARELO);
  end

  for (genvar i = 0; i < N_VIAS; i++) begin : g_via
    assign luzes_d[3*i +: 3] = (via_d != 3'(i)) ? 3'b100 :
                               verde_d          ? 3'b001 :
                               amarelo_d        ? 3'b010 : 3'b100;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q    <= VERDE;
      cnt_q       <= 8'd0;
      via_q       <= 3'd0;
      pedido_q    <= 1'b0;
      ped_verde_q <= 1'b0;
      luzes_q     <= LUZES_RST;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      via_q       <= via_d;
      pedido_q    <= pedido_d;
      ped_verde_q <= ped_verde_d;
      luzes_q     <= luzes_d;
    end
  end

  assign luzes     = luzes_q;
  assign ped_verde = ped_verde_q;
  assign pedido    = pedido_q;
  assign via_ativa = via_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// Bench for semaforo_multi: phase-countdown model checked every cycle, plus
// literal expectations taken from hand-worked timelines of directed scenarios.
module tb_semaforo_multi;

  localparam int N    = 3;
  localparam int TV   = 4;
  localparam int TA   = 2;
  localparam int TR   = 1;
  localparam int TMIN = 2;
  localparam int TP   = 3;
  localparam int ALLRED  = 9'b100100100;
  localparam int RST_LUZ = 9'b100100001;

  localparam int PH_G = 0, PH_Y = 1, PH_R = 2, PH_P = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           bt  = 1'b0;
  logic [3*N-1:0] luzes;
  logic           ped_verde, pedido;
  logic [2:0]     via_ativa;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  semaforo_multi #(
    .N_VIAS(N), .T_VERDE(TV), .T_AMARELO(TA), .T_VERMELHO(TR),
    .T_VERDE_MIN(TMIN), .T_PED(TP)
  ) dut (
    .clk(clk), .rst(rst), .bt(bt), .luzes(luzes),
    .ped_verde(ped_verde), .pedido(pedido), .via_ativa(via_ativa)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lamp(input int i);
    return int'(luzes[3*i +: 3]);
  endfunction

  // Model: current phase, cycles left in it, cycles already spent in it (1-based).
  int m_ph, m_left, m_age, m_via;
  bit m_req;

  function automatic int dur(input int ph);
    case (ph)
      PH_G:    return TV;
      PH_Y:    return TA;
      PH_R:    return TR;
      default: return TP;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = PH_G; m_left = TV; m_age = 1; m_via = 0; m_req = 1'b0;
    end else begin
      int  nph;
      int  nvia;
      bit  nreq;
      bit  done;
      nph = m_ph; nvia = m_via; nreq = m_req; done = 1'b0;
      case (m_ph)
        PH_G: begin done = (m_left == 1) || (m_req && m_age >= TMIN); nph = PH_Y; end
        PH_Y: begin done = (m_left == 1); nph = PH_R; end
        PH_R: begin
          done = (m_left == 1);
          nph  = m_req ? PH_P : PH_G;
          if (!m_req) nvia = (m_via + 1) % N;
        end
        default: begin done = (m_left == 1); nph = PH_G; nvia = (m_via + 1) % N; end
      endcase
      if (bt && m_ph != PH_P) nreq = 1'b1;
      if (done && nph == PH_P) nreq = 1'b0;
      if (done) begin
        m_ph = nph; m_via = nvia; m_left = dur(nph); m_age = 1;
      end else begin
        m_left--; m_age++;
      end
      m_req = nreq;
    end
  end

  function automatic int exp_luzes();
    int v = 0;
    for (int i = 0; i < N; i++) begin
      int code;
      code = 4;
      if (i == m_via && m_ph == PH_G) code = 1;
      if (i == m_via && m_ph == PH_Y) code = 2;
      v = v | (code << (3*i));
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int nonred;
      nonred = 0;
      chk("luzes", int'(luzes), exp_luzes());
      chk("ped_verde", int'(ped_verde), int'(m_ph == PH_P));
      chk("pedido", int'(pedido), int'(m_req));
      chk("via_ativa", int'(via_ativa), m_via);
      for (int i = 0; i < N; i++) if (lamp(i) != 4) nonred++;
      chk("safety_one_active", int'(nonred <= 1), 1);
      if (ped_verde) chk("safety_ped_allred", nonred, 0);
    end
  end

  task automatic lit(input int scn, input int c);
    case (scn)
      0: begin
        if (c <= 3) chk("s0_v0_green", lamp(0), 1);
        else if (c <= 5) chk("s0_v0_yellow", lamp(0), 2);
        else if (c == 6) chk("s0_allred", int'(luzes), ALLRED);
        else if (c <= 10) chk("s0_v1_green", lamp(1), 1);
        if (c == 20) chk("s0_via2", int'(via_ativa), 2);
        if (c == 21) begin
          chk("s0_v0_again", lamp(0), 1);
          chk("s0_via_wrap", int'(via_ativa), 0);
        end
      end
      1: begin
        if (c == 1) chk("s1_pedido", int'(pedido), 1);
        if (c == 2 || c == 3) chk("s1_v0_yellow", lamp(0), 2);
        if (c == 4) chk("s1_allred", int'(luzes), ALLRED);
        if (c >= 5 && c <= 7) chk("s1_ped", int'(ped_verde), 1);
        if (c == 5) chk("s1_pedido_clr", int'(pedido), 0);
        if (c == 8) begin
          chk("s1_v1_green", lamp(1), 1);
          chk("s1_ped_off", int'(ped_verde), 0);
        end
      end
      2: begin
        if (c == 5) chk("s2_v0_yellow", lamp(0), 2);
        if (c == 6) begin
          chk("s2_allred", int'(luzes), ALLRED);
          chk("s2_pedido", int'(pedido), 1);
        end
        if (c >= 7 && c <= 9) chk("s2_ped", int'(ped_verde), 1);
        if (c == 10) chk("s2_v1_green", lamp(1), 1);
      end
      3: begin
        if ((c >= 5 && c <= 7) || (c >= 13 && c <= 15) || (c >= 21 && c <= 23))
          chk("s3_ped", int'(ped_verde), 1);
        if (c >= 5 && c <= 8) chk("s3_no_latch", int'(pedido), 0);
        if (c == 8 || c == 9) chk("s3_v1_green", lamp(1), 1);
        if (c == 9) chk("s3_rerequest", int'(pedido), 1);
        if (c == 10) chk("s3_v1_yellow", lamp(1), 2);
        if (c == 24) chk("s3_pedido_idle", int'(pedido), 0);
        if (c == 24 || c == 27) chk("s3_v0_green", lamp(0), 1);
      end
      4: begin
        if (c == 11) begin
          chk("s4_v1_yellow", lamp(1), 2);
          chk("s4_pedido", int'(pedido), 1);
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic run_scn(input int scn, input int b0, input int b1, input int n);
    do_reset();
    for (int c = 0; c < n; c++) begin
      bt = (c >= b0 && c <= b1);
      #3;
      lit(scn, c);
      @(posedge clk);
      #1;
    end
    bt = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    run_scn(0, -1, -1, 24);
    run_scn(1, 0, 0, 12);
    run_scn(2, 5, 5, 14);
    run_scn(3, 0, 20, 30);
    run_scn(4, 10, 10, 12);
    // mid-cycle asynchronous reset during approach 1 yellow
    #2 rst = 1'b0;
    #1;
    chk("s4_rst_luzes", int'(luzes), RST_LUZ);
    chk("s4_rst_pedido", int'(pedido), 0);
    chk("s4_rst_ped", int'(ped_verde), 0);
    chk("s4_rst_via", int'(via_ativa), 0);
    run_scn(0, -1, -1, 24);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
